// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Frames bytes from a UART receiver into 4-byte register-write
//            commands {sync, addr, data, checksum}. A frame whose checksum
//            matches the 8-bit sum of the first three bytes produces a
//            one-cycle write strobe. A bad checksum or an inter-byte stall
//            produces a one-cycle error pulse and a held cause code.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            rx_byte[7:0]        - received byte
//            rx_byte_valid       - one-cycle byte-valid pulse
//            reg_wr_en           - one-cycle write strobe (validated frame)
//            reg_wr_addr[7:0]    - write address, held until next good frame
//            reg_wr_data[7:0]    - write data, held until next good frame
//            frame_err           - one-cycle error pulse
//            err_code[1:0]       - 0 none, 1 checksum, 2 timeout (held)
//            frame_cnt[CNT_W-1:0]- good-frame count, wraps
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1500,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_byte_valid,
    output logic             reg_wr_en,
    output logic [7:0]       reg_wr_addr,
    output logic [7:0]       reg_wr_data,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] frame_cnt
);

    // The counter only has to reach TIMEOUT_CYC-1.
    localparam int c_TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_S_SYNC = 2'd0;
    localparam logic [1:0] c_S_ADDR = 2'd1;
    localparam logic [1:0] c_S_DATA = 2'd2;
    localparam logic [1:0] c_S_CSUM = 2'd3;

    localparam logic [1:0] c_ERR_NONE = 2'd0;
    localparam logic [1:0] c_ERR_CSUM = 2'd1;
    localparam logic [1:0] c_ERR_TOUT = 2'd2;

    logic [1:0]        r_state;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_addr;
    logic [7:0]        r_data;
    logic [7:0]        r_sum;
    logic              r_wr_en;
    logic [7:0]        r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_frame_err;
    logic [1:0]        r_err_code;
    logic [CNT_W-1:0]  r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_SYNC;
            r_to_cnt    <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_sum       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            r_err_code  <= c_ERR_NONE;
            r_frame_cnt <= '0;
        end else begin
            // Strobes are single-cycle by default.
            r_wr_en     <= 1'b0;
            r_frame_err <= 1'b0;

            if (rx_byte_valid) begin
                // A byte always takes priority over an expiring timeout.
                r_to_cnt <= '0;
                case (r_state)
                    c_S_SYNC: begin
                        if (rx_byte == SYNC_BYTE) begin
                            r_sum   <= SYNC_BYTE;
                            r_state <= c_S_ADDR;
                        end
                    end
                    c_S_ADDR: begin
                        // Sync value here is payload, not a resync.
                        r_addr  <= rx_byte;
                        r_sum   <= r_sum + rx_byte;
                        r_state <= c_S_DATA;
                    end
                    c_S_DATA: begin
                        r_data  <= rx_byte;
                        r_sum   <= r_sum + rx_byte;
                        r_state <= c_S_CSUM;
                    end
                    c_S_CSUM: begin
                        r_state <= c_S_SYNC;
                        if (rx_byte == r_sum) begin
                            r_wr_en     <= 1'b1;
                            r_wr_addr   <= r_addr;
                            r_wr_data   <= r_data;
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            r_err_code  <= c_ERR_NONE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= c_ERR_CSUM;
                        end
                    end
                    default: r_state <= c_S_SYNC;
                endcase
            end else if (r_state != c_S_SYNC) begin
                if (r_to_cnt == c_TO_LAST) begin
                    r_state     <= c_S_SYNC;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                    r_err_code  <= c_ERR_TOUT;
                end else begin
                    r_to_cnt <= r_to_cnt + c_TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign reg_wr_en   = r_wr_en;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign frame_err   = r_frame_err;
    assign err_code    = r_err_code;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Purpose  : Directed self-checking bench for uart_cmd_parser (CNT_W=2 so
//            the good-frame counter wrap is reachable).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_parser;

    localparam int c_TO    = 1500;
    localparam int c_CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_byte = 8'h00;
    logic             rx_byte_valid = 1'b0;
    logic             reg_wr_en;
    logic [7:0]       reg_wr_addr;
    logic [7:0]       reg_wr_data;
    logic             frame_err;
    logic [1:0]       err_code;
    logic [c_CNT_W-1:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;
    int err_pulses = 0;
    int snap_wr;
    int snap_err;

    uart_cmd_parser #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (c_TO),
        .CNT_W       (c_CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (reg_wr_en) wr_pulses++;
        if (frame_err) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte is sampled at the first posedge after 'gap' idle cycles; task
    // returns 1ns after that sampling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input int gap);
        send_byte(8'hA5, gap);
        send_byte(a, gap);
        send_byte(d, gap);
        send_byte(c, gap);
    endtask

    function automatic logic [7:0] csum(input logic [7:0] a, input logic [7:0] d);
        return 8'hA5 + a + d;
    endfunction

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(reg_wr_en), 32'h0);
        check("rst_addr", 32'(reg_wr_addr), 32'h0);
        check("rst_data", 32'(reg_wr_data), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_code", 32'(err_code), 32'h0);
        check("rst_cnt", 32'(frame_cnt), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- good frame, 500 clk spacing ----------------
        send_byte(8'hA5, 500);
        send_byte(8'h12, 500);
        send_byte(8'h34, 500);
        check("good_no_early_wr", 32'(reg_wr_en), 32'h0);
        send_byte(8'hEB, 500);
        check("good_wr_en", 32'(reg_wr_en), 32'h1);
        check("good_addr", 32'(reg_wr_addr), 32'h12);
        check("good_data", 32'(reg_wr_data), 32'h34);
        check("good_cnt", 32'(frame_cnt), 32'h1);
        @(posedge clk);
        #1;
        check("good_wr_single", 32'(reg_wr_en), 32'h0);
        check("good_wr_pulses", 32'(wr_pulses), 32'd1);
        check("good_no_err", 32'(err_pulses), 32'd0);

        // ---------------- checksum wrap ----------------
        send_frame(8'hFF, 8'h02, 8'hA6, 3);
        check("wrap_wr_en", 32'(reg_wr_en), 32'h1);
        check("wrap_addr", 32'(reg_wr_addr), 32'hFF);
        check("wrap_data", 32'(reg_wr_data), 32'h02);
        check("wrap_cnt", 32'(frame_cnt), 32'h2);

        // ---------------- bad checksum ----------------
        send_frame(8'hFF, 8'h02, 8'hA7, 3);
        check("bad_err", 32'(frame_err), 32'h1);
        check("bad_code", 32'(err_code), 32'h1);
        check("bad_no_wr", 32'(reg_wr_en), 32'h0);
        check("bad_addr_held", 32'(reg_wr_addr), 32'hFF);
        check("bad_data_held", 32'(reg_wr_data), 32'h02);
        check("bad_cnt_held", 32'(frame_cnt), 32'h2);
        @(posedge clk);
        #1;
        check("bad_err_single", 32'(frame_err), 32'h0);
        check("bad_code_held", 32'(err_code), 32'h1);
        check("bad_err_pulses", 32'(err_pulses), 32'd1);

        // ---------------- garbage + sync as payload ----------------
        snap_wr = wr_pulses;
        send_byte(8'h00, 2);
        send_byte(8'h3C, 2);
        send_frame(8'hA5, 8'hA5, 8'hEF, 2);
        check("garb_wr_en", 32'(reg_wr_en), 32'h1);
        check("garb_addr", 32'(reg_wr_addr), 32'hA5);
        check("garb_data", 32'(reg_wr_data), 32'hA5);
        check("garb_code", 32'(err_code), 32'h0);
        check("garb_cnt", 32'(frame_cnt), 32'h3);
        @(posedge clk);
        #1;
        check("garb_one_wr", 32'(wr_pulses), 32'(snap_wr + 1));
        check("garb_no_err", 32'(err_pulses), 32'd1);

        // ---------------- timeout ----------------
        send_byte(8'hA5, 2);
        send_byte(8'h12, 2);
        repeat (c_TO - 1) @(posedge clk);
        #1;
        check("to_not_early", 32'(frame_err), 32'h0);
        @(posedge clk);
        #1;
        check("to_err", 32'(frame_err), 32'h1);
        check("to_code", 32'(err_code), 32'h2);
        check("to_cnt_held", 32'(frame_cnt), 32'h3);
        send_frame(8'h12, 8'h34, 8'hEB, 2);
        check("to_recover_wr", 32'(reg_wr_en), 32'h1);
        check("to_recover_cnt", 32'(frame_cnt), 32'h0);
        check("to_recover_code", 32'(err_code), 32'h0);

        // ---------------- byte on the last timeout cycle ----------------
        snap_err = err_pulses;
        send_byte(8'hA5, 2);
        send_byte(8'h12, 2);
        send_byte(8'h34, c_TO - 1);
        check("bnd_no_err", 32'(frame_err), 32'h0);
        send_byte(8'hEB, 2);
        check("bnd_wr_en", 32'(reg_wr_en), 32'h1);
        check("bnd_cnt", 32'(frame_cnt), 32'h1);
        @(posedge clk);
        #1;
        check("bnd_err_pulses", 32'(err_pulses), 32'(snap_err));

        // ---------------- reset mid-frame ----------------
        send_byte(8'hA5, 2);
        send_byte(8'h12, 2);
        rst = 1'b1;
        #2;
        check("mrst_wr_en", 32'(reg_wr_en), 32'h0);
        check("mrst_addr", 32'(reg_wr_addr), 32'h0);
        check("mrst_data", 32'(reg_wr_data), 32'h0);
        check("mrst_err", 32'(frame_err), 32'h0);
        check("mrst_code", 32'(err_code), 32'h0);
        check("mrst_cnt", 32'(frame_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        snap_wr  = wr_pulses;
        snap_err = err_pulses;

        // ---------------- five good frames: counter 1,2,3,0,1 ----------------
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            logic [1:0] exp_cnt;
            a = 8'(8'h20 + i);
            d = 8'(8'hC0 + 3 * i);
            exp_cnt = 2'(i + 1);
            send_frame(a, d, csum(a, d), 2);
            check($sformatf("cw_wr_%0d", i), 32'(reg_wr_en), 32'h1);
            check($sformatf("cw_addr_%0d", i), 32'(reg_wr_addr), 32'(a));
            check($sformatf("cw_data_%0d", i), 32'(reg_wr_data), 32'(d));
            check($sformatf("cw_cnt_%0d", i), 32'(frame_cnt), 32'(exp_cnt));
        end
        @(posedge clk);
        #1;
        check("cw_wr_pulses", 32'(wr_pulses), 32'(snap_wr + 5));
        check("cw_no_err", 32'(err_pulses), 32'(snap_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
